// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// ALU codes, datapath select codes and the FSM state type.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALU_SRC_B_REG     = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADR  = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_IMM_EX   = 4'd8,
    S_IMM_WB   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12
  } state_e;

  // Which ALU operation a state asks for; resolved to a code by alu_decoder.
  typedef enum logic [2:0] {
    ALU_CLS_NONE  = 3'd0,
    ALU_CLS_ADD   = 3'd1,
    ALU_CLS_SUB   = 3'd2,
    ALU_CLS_FUNCT = 3'd3,
    ALU_CLS_IMM   = 3'd4
  } alu_cls_e;

  function automatic logic is_rtype_alu(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Combinational ALU-control decode from state class, opcode and funct.
module alu_decoder
  import mips_mc_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o
);

  // Map the requested class to a concrete ALU code; unlisted cases read AND (0).
  always_comb begin
    alu_ctrl_o = ALU_AND;
    case (cls_i)
      ALU_CLS_ADD: alu_ctrl_o = ALU_ADD;
      ALU_CLS_SUB: alu_ctrl_o = ALU_SUB;
      ALU_CLS_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
      ALU_CLS_IMM: alu_ctrl_o = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
      default:     alu_ctrl_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM driving datapath selects/enables,
// branch-qualified zero, and a retired-instruction pulse and counter.
module mc_controller
  import mips_mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             zero_to_dp,
  output logic [1:0]       reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_ctrl,
  output logic             reg_write,
  output logic             IorD,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  alu_cls_e         alu_cls;

  logic reg_write_raw, pc_write_raw, pc_write_cond_raw, ir_write_raw;
  logic mem_read_raw, mem_write_raw, done_raw;

  // State register; reset parks the FSM in FETCH.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and Moore output decode; every output defaults to 0.
  always_comb begin
    state_d           = S_FETCH;
    reg_dst           = REG_DST_RT;
    mem_to_reg        = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = ALU_SRC_B_REG;
    pc_src            = PC_SRC_ALU;
    alu_cls           = ALU_CLS_NONE;
    IorD              = 1'b0;
    reg_write_raw     = 1'b0;
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    ir_write_raw      = 1'b0;
    mem_read_raw      = 1'b0;
    mem_write_raw     = 1'b0;
    done_raw          = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        ir_write_raw = 1'b1;
        alu_src_b    = ALU_SRC_B_FOUR;
        alu_cls      = ALU_CLS_ADD;
        pc_src       = PC_SRC_ALU;
        pc_write_raw = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = ALU_SRC_B_IMM_SH2;
        alu_cls   = ALU_CLS_ADD;
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEM_ADR;
          OP_ADDI, OP_SLTI: state_d = S_IMM_EX;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_RTYPE: begin
            if (is_rtype_alu(funct))  state_d = S_RTYPE_EX;
            else if (funct == FN_JR)  state_d = S_JR;
            else                      done_raw = 1'b1;
          end
          default: done_raw = 1'b1;
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_SRC_B_IMM;
        alu_cls   = ALU_CLS_ADD;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        IorD         = 1'b1;
        mem_read_raw = 1'b1;
        state_d      = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_dst       = REG_DST_RT;
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_MEM_WR: begin
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_SRC_B_REG;
        alu_cls   = ALU_CLS_FUNCT;
        state_d   = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        reg_dst       = REG_DST_RD;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_IMM_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_SRC_B_IMM;
        alu_cls   = ALU_CLS_IMM;
        state_d   = S_IMM_WB;
      end
      S_IMM_WB: begin
        reg_dst       = REG_DST_RT;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a         = 1'b1;
        alu_src_b         = ALU_SRC_B_REG;
        alu_cls           = ALU_CLS_SUB;
        pc_src            = PC_SRC_ALUOUT;
        pc_write_cond_raw = 1'b1;
        done_raw          = 1'b1;
      end
      S_JUMP: begin
        pc_src       = PC_SRC_JUMP;
        pc_write_raw = 1'b1;
        done_raw     = 1'b1;
      end
      S_JR: begin
        pc_src       = PC_SRC_REG;
        pc_write_raw = 1'b1;
        done_raw     = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .cls_i      (alu_cls),
    .opcode_i   (opcode),
    .funct_i    (funct),
    .alu_ctrl_o (alu_ctrl)
  );

  // Enables and the retire pulse are masked while reset is held so an
  // abandoned instruction never writes state.
  assign reg_write     = reg_write_raw     & ~rst;
  assign pc_write      = pc_write_raw      & ~rst;
  assign pc_write_cond = pc_write_cond_raw & ~rst;
  assign ir_write      = ir_write_raw      & ~rst;
  assign mem_read      = mem_read_raw      & ~rst;
  assign mem_write     = mem_write_raw     & ~rst;
  assign instr_done    = done_raw          & ~rst;

  assign zero_to_dp = (opcode == OP_BEQ) ? zero :
                      (opcode == OP_BNE) ? ~zero : 1'b0;

  // Retired-instruction counter next value; wraps naturally.
  always_comb begin
    instr_count_d = instr_count_q;
    if (instr_done) instr_count_d = instr_count_q + CNT_W'(1);
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk) begin
    if (rst) instr_count_q <= '0;
    else     instr_count_q <= instr_count_d;
  end

  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized self-checking bench for mc_controller against a per-instruction
// step-table reference model.
module tb_mc_controller;

  localparam int unsigned CW = 4;

  logic          clk, rst, zero;
  logic [5:0]    opcode, funct;
  logic          zero_to_dp, mem_to_reg, alu_src_a;
  logic [1:0]    reg_dst, alu_src_b, pc_src;
  logic [2:0]    alu_ctrl;
  logic          reg_write, IorD, pc_write, pc_write_cond, ir_write;
  logic          mem_read, mem_write, instr_done;
  logic [CW-1:0] instr_count;

  mc_controller #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .zero_to_dp(zero_to_dp), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_ctrl(alu_ctrl), .reg_write(reg_write), .IorD(IorD),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .instr_done(instr_done),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_ctrl;
    logic       reg_write;
    logic       IorD;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       instr_done;
  } ctrl_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_IMM = 3, K_BR = 4, K_J = 5,
                 K_JR = 6, K_ILL = 7;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         kind;
    logic [2:0] alu;
  } instr_t;

  instr_t legal_tab[13];

  int          checks = 0;
  int          errors = 0;
  logic [CW-1:0] count_m = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int latency(input int kind);
    case (kind)
      K_LW:                   return 5;
      K_SW, K_R, K_IMM:       return 4;
      K_BR, K_J, K_JR:        return 3;
      default:                return 2;
    endcase
  endfunction

  // Expected control bundle for a given instruction on a given cycle of it.
  function automatic ctrl_t model(input instr_t in, input int step);
    ctrl_t c = '0;
    if (step == 0) begin
      c.mem_read = 1; c.ir_write = 1; c.alu_src_b = 2'b01;
      c.alu_ctrl = 3'b010; c.pc_write = 1;
    end else if (step == 1) begin
      c.alu_src_b = 2'b11; c.alu_ctrl = 3'b010;
    end else begin
      case (in.kind)
        K_LW, K_SW: begin
          if (step == 2) begin
            c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_ctrl = 3'b010;
          end else if (step == 3 && in.kind == K_LW) begin
            c.IorD = 1; c.mem_read = 1;
          end else if (step == 3) begin
            c.IorD = 1; c.mem_write = 1;
          end else begin
            c.mem_to_reg = 1; c.reg_write = 1;
          end
        end
        K_R: begin
          if (step == 2) begin
            c.alu_src_a = 1; c.alu_ctrl = in.alu;
          end else begin
            c.reg_dst = 2'b01; c.reg_write = 1;
          end
        end
        K_IMM: begin
          if (step == 2) begin
            c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_ctrl = in.alu;
          end else begin
            c.reg_write = 1;
          end
        end
        K_BR: begin
          c.alu_src_a = 1; c.alu_ctrl = 3'b110; c.pc_src = 2'b10;
          c.pc_write_cond = 1;
        end
        K_J:  begin c.pc_src = 2'b01; c.pc_write = 1; end
        K_JR: begin c.pc_src = 2'b11; c.pc_write = 1; end
        default: ;
      endcase
    end
    c.instr_done = (step == latency(in.kind) - 1);
    return c;
  endfunction

  function automatic logic exp_zdp(input logic [5:0] op, input logic z);
    if (op == 6'b000100) return z;
    if (op == 6'b000101) return ~z;
    return 1'b0;
  endfunction

  function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
    foreach (legal_tab[i])
      if (legal_tab[i].op == op &&
          (legal_tab[i].kind != K_R && legal_tab[i].kind != K_JR || legal_tab[i].fn == fn))
        return 1;
    return 0;
  endfunction

  function automatic ctrl_t observed();
    ctrl_t c;
    c = '{reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_ctrl,
          reg_write, IorD, pc_write, pc_write_cond, ir_write, mem_read,
          mem_write, instr_done};
    return c;
  endfunction

  // Run one instruction from FETCH; stop_after < 0 runs it to completion.
  task automatic run_instr(input instr_t in, input int zmode, input int stop_after);
    int n;
    ctrl_t e;
    n = latency(in.kind);
    if (stop_after >= 0 && stop_after < n) n = stop_after;
    opcode = in.op;
    funct  = in.fn;
    for (int s = 0; s < n; s++) begin
      zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
      @(negedge clk);
      e = model(in, s);
      chk($sformatf("ctrl op=%b fn=%b step%0d", in.op, in.fn, s),
          32'(observed()), 32'(e));
      chk("zero_to_dp", 32'(zero_to_dp), 32'(exp_zdp(in.op, zero)));
      chk("instr_count", 32'(instr_count), 32'(count_m));
      if (e.instr_done) count_m = count_m + 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("reset enables",
          32'({pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, instr_done}),
          32'(0));
      if (i > 0) chk("reset count", 32'(instr_count), 32'(0));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    count_m = '0;
  endtask

  function automatic instr_t mk(input logic [5:0] op, input logic [5:0] fn,
                                input int kind, input logic [2:0] alu);
    instr_t t;
    t.op = op; t.fn = fn; t.kind = kind; t.alu = alu;
    return t;
  endfunction

  initial begin
    instr_t t;
    legal_tab[0]  = mk(6'b100011, 6'd0, K_LW, 3'b000);
    legal_tab[1]  = mk(6'b101011, 6'd0, K_SW, 3'b000);
    legal_tab[2]  = mk(6'b000000, 6'b100000, K_R, 3'b010);
    legal_tab[3]  = mk(6'b000000, 6'b100010, K_R, 3'b110);
    legal_tab[4]  = mk(6'b000000, 6'b100100, K_R, 3'b000);
    legal_tab[5]  = mk(6'b000000, 6'b100101, K_R, 3'b001);
    legal_tab[6]  = mk(6'b000000, 6'b101010, K_R, 3'b111);
    legal_tab[7]  = mk(6'b000000, 6'b001000, K_JR, 3'b000);
    legal_tab[8]  = mk(6'b001000, 6'd0, K_IMM, 3'b010);
    legal_tab[9]  = mk(6'b001010, 6'd0, K_IMM, 3'b111);
    legal_tab[10] = mk(6'b000100, 6'd0, K_BR, 3'b000);
    legal_tab[11] = mk(6'b000101, 6'd0, K_BR, 3'b000);
    legal_tab[12] = mk(6'b000010, 6'd0, K_J, 3'b000);

    rst = 1'b1; zero = 1'b0; opcode = 6'b100011; funct = 6'd0;
    do_reset(2);

    // Directed walk through the main instruction classes.
    run_instr(legal_tab[0], -1, -1);
    run_instr(legal_tab[3], -1, -1);
    run_instr(legal_tab[10], 1, -1);
    run_instr(legal_tab[11], 1, -1);
    run_instr(legal_tab[12], -1, -1);
    run_instr(legal_tab[7], -1, -1);
    run_instr(mk(6'b111111, 6'd0, K_ILL, 3'b000), -1, -1);

    // Reset landing in MEM_RD of a lw, then normal operation resumes.
    run_instr(legal_tab[0], -1, 3);
    do_reset(2);
    run_instr(legal_tab[0], -1, -1);

    // Random stream of legal and illegal instructions.
    for (int k = 0; k < 150; k++) begin
      int r;
      r = int'($urandom_range(0, 14));
      if (r < 13) begin
        t = legal_tab[r];
        if (t.kind != K_R && t.kind != K_JR) t.fn = 6'($urandom);
      end else begin
        do begin
          t.op = 6'($urandom);
          t.fn = 6'($urandom);
        end while (is_legal(t.op, t.fn));
        t.kind = K_ILL;
        t.alu  = 3'b000;
      end
      run_instr(t, -1, -1);
    end

    // Counter wrap after 2^CW retirements.
    do_reset(2);
    for (int k = 0; k < (1 << CW); k++) run_instr(legal_tab[1], -1, -1);
    @(negedge clk);
    chk("count wrap", 32'(instr_count), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
